y86_ins_encoder: RTL and testbench
==================================

Name: y86_ins_encoder

Overview:
- Write-side counterpart of the fetch stage: accepts one decoded Y86 instruction per handshake (icode, ifun, rA, rB, valC) and serialises it into instruction memory, one byte per cycle.
- Byte layout and per-icode length are exactly those the fetch stage decodes, so programs written through this block fetch back field-for-field.
- Sits between the testbench/program loader and the instruction memory write port; tracks a write PC that advances like valP.

Parameters:
- MEM_SIZE, 128, instruction memory size in bytes; no byte is written at or above this address.
- ADDR_W, 64, width of PC and memory address.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- addr_load  input  1  load write PC from addr_val (IDLE only)
- addr_val  input  ADDR_W  new write PC
- in_valid  input  1  instruction fields valid
- in_ready  output  1  block can accept an instruction
- icode  input  4  instruction code
- ifun  input  4  function code
- rA  input  4  register A specifier
- rB  input  4  register B specifier
- valC  input  64  constant word
- mem_we  output  1  byte write strobe
- mem_addr  output  ADDR_W  byte address
- mem_data  output  8  byte to write
- ins_done  output  1  one-cycle pulse with the last byte of an instruction
- err  output  1  one-cycle pulse when an instruction is rejected
- err_code  output  2  0 = none, 1 = bad icode, 2 = overflow; held until the next accept
- pc  output  ADDR_W  current write PC (next instruction start)

Behaviour:
- Reset (async, high): state IDLE, pc=0, mem_we=0, mem_addr=0, mem_data=0, ins_done=0, err=0, err_code=0, internal byte counter=0.
- Length by icode: 0 halt, 1 nop, 9 ret -> 1 byte. 2 cmovXX, 6 OPq, A pushq, B popq -> 2 bytes. 3 irmovq, 4 rmmovq, 5 mrmovq -> 10 bytes. 7 jXX, 8 call -> 9 bytes. icode C..F is invalid.
- Byte 0 = {icode, ifun}.
- 2- and 10-byte forms: byte 1 = {rA, rB}; 10-byte forms add valC little-endian in bytes 2..9.
- 9-byte forms: valC little-endian in bytes 1..8; rA and rB are ignored.
- Fields are emitted exactly as given; no register-field substitution.
- States: IDLE, EMIT.
- in_ready = (state==IDLE) && !addr_load, combinational. It stays low while HALT_LOCK is set (see Optional Feature).
- IDLE, addr_load=1: pc <= addr_val. addr_load has priority over in_valid; no accept that cycle. addr_load in EMIT is ignored.
- IDLE, in_valid && in_ready: fields are latched and err_code is cleared.
  - Bad icode: err pulses next cycle, err_code=1, no writes, pc unchanged, stay IDLE.
  - Overflow (pc + len > MEM_SIZE, computed without wrap): err pulses next cycle, err_code=2, no writes, pc unchanged, stay IDLE.
  - Otherwise go to EMIT.
- EMIT: one byte per cycle, starting the cycle after accept. mem_we=1, mem_addr = pc + k, mem_data = byte k, for k = 0..len-1.
- Last byte: ins_done=1 in the same cycle, pc <= pc + len (equals fetch valP), return to IDLE. in_ready rises the following cycle.
- Throughput: len+1 cycles per instruction.
- mem_we, ins_done, err are registered; they are 0 whenever not asserted as above.
- Reset mid-EMIT: the transfer is aborted immediately, partially written bytes remain in memory, and all state returns to reset values.

Optional Feature:
- Macro INS_HALT_LOCK_EN.
- Defined: after a halt (icode 0) is emitted, a HALT_LOCK flag is set. While set, in_ready=0. addr_load clears the flag and loads pc. Reset clears it.
- Undefined: there is no lock; halt behaves like any 1-byte instruction and in_ready returns high after it.

Test Plan:
- Reset, then irmovq (3,0,F,2,valC=0x64) -> addr 0..9 receive 30 F2 64 00 00 00 00 00 00 00; ins_done with mem_addr=9; pc=10.
- Then call (8,0,valC=0x40) -> addr 10..18 receive 80 40 00 00 00 00 00 00 00; pc=19. Then OPq (6,1,rA=3,rB=4) -> 61 34 at 19..20; pc=21.
- Bad icode 0xC at pc=21 -> err pulse, err_code=1, no mem_we, pc stays 21. addr_load 120 then irmovq -> err_code=2, no writes, pc=120.
- addr_load 127, halt -> byte 00 at 127, pc=128. With INS_HALT_LOCK_EN, in_ready stays 0 until addr_load 0; without the macro, in_ready=1 next cycle.
- Assert reset during byte 4 of an rmmovq -> mem_we=0 and pc=0 asynchronously; in_ready=1 after release.
- addr_load=1 and in_valid=1 together in IDLE -> pc loaded, no accept, in_ready=0 that cycle.

Source files
------------

// File: rtl/y86_ins_encoder.sv
//------------------------------------------------------------------------------
// Module  : y86_ins_encoder
// Brief   : Serialises one decoded Y86 instruction into instruction memory,
//           one byte per cycle. Optional halt lock: INS_HALT_LOCK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module y86_ins_encoder #(
    parameter int MEM_SIZE = 128,
    parameter int ADDR_W   = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              ins_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_cnt;
    logic [3:0]        r_len;
    logic [3:0]        r_rA;
    logic [3:0]        r_rB;
    logic [63:0]       r_valC;

    logic [3:0]        w_len;
    logic              w_bad;
    logic              w_ovf;
    logic              w_accept;
    logic              w_last;
    logic              w_lock;
    logic [2:0]        w_vidx;
    logic [7:0]        w_byte;
    logic [ADDR_W:0]   w_end;

    function automatic logic [3:0] f_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       f_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: f_len = 4'd2;
            4'h3, 4'h4, 4'h5:       f_len = 4'd10;
            4'h7, 4'h8:             f_len = 4'd9;
            default:                f_len = 4'd0;
        endcase
    endfunction

    assign w_len    = f_len(icode);
    assign w_bad    = (w_len == 4'd0);
    // One extra bit so pc + len never wraps before the bound check.
    assign w_end    = {1'b0, r_pc} + (ADDR_W+1)'(w_len);
    assign w_ovf    = (w_end > (ADDR_W+1)'(MEM_SIZE));
    assign in_ready = (r_state == S_IDLE) && !addr_load && !w_lock;
    assign w_accept = in_valid && in_ready;
    // r_cnt is the index of the byte to present next; equal to len means done.
    assign w_last   = (r_state == S_EMIT) && (r_cnt == r_len);

    // valC starts at byte 1 for jXX/call and at byte 2 for the register forms.
    assign w_vidx   = (r_len == 4'd9) ? (r_cnt[2:0] - 3'd1) : (r_cnt[2:0] - 3'd2);
    assign w_byte   = ((r_len != 4'd9) && (r_cnt == 4'd1)) ? {r_rA, r_rB}
                                                           : r_valC[{w_vidx, 3'b000} +: 8];

    assign pc       = r_pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !w_bad && !w_ovf) w_state_nxt = S_EMIT;
            S_EMIT: if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_rA     <= '0;
            r_rB     <= '0;
            r_valC   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            ins_done <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else begin
            mem_we   <= 1'b0;
            ins_done <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (addr_load) begin
                        r_pc <= addr_val;
                    end else if (w_accept) begin
                        r_len    <= w_len;
                        r_rA     <= rA;
                        r_rB     <= rB;
                        r_valC   <= valC;
                        err_code <= 2'd0;
                        if (w_bad) begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end else if (w_ovf) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end else begin
                            mem_we   <= 1'b1;
                            mem_addr <= r_pc;
                            mem_data <= {icode, ifun};
                            ins_done <= (w_len == 4'd1);
                            r_cnt    <= 4'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_last) begin
                        r_pc  <= r_pc + ADDR_W'(r_len);
                        r_cnt <= '0;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= r_pc + ADDR_W'(r_cnt);
                        mem_data <= w_byte;
                        ins_done <= ((r_cnt + 4'd1) == r_len);
                        r_cnt    <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INS_HALT_LOCK_EN
    logic r_lock;
    logic r_halt;

    assign w_lock = r_lock;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lock <= 1'b0;
            r_halt <= 1'b0;
        end else begin
            if (w_accept) r_halt <= (icode == 4'h0);
            if ((r_state == S_IDLE) && addr_load) r_lock <= 1'b0;
            else if (w_last && r_halt)            r_lock <= 1'b1;
        end
    end
`else
    assign w_lock = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_y86_ins_encoder.sv
//------------------------------------------------------------------------------
// Module  : tb_y86_ins_encoder
// Brief   : Scoreboard bench for y86_ins_encoder with a byte-list reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_y86_ins_encoder;

    localparam int MEM_SIZE = 128;
    localparam int ADDR_W   = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              addr_load = 1'b0;
    logic [ADDR_W-1:0] addr_val = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        icode = '0, ifun = '0, rA = '0, rB = '0;
    logic [63:0]       valC = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              ins_done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] pc;

    y86_ins_encoder #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .addr_load(addr_load), .addr_val(addr_val),
        .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .ins_done(ins_done), .err(err), .err_code(err_code),
        .pc(pc)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  data;
        logic        last;
    } wr_t;

    wr_t         wq[$];
    int          eq[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_pc = '0;
    bit          m_lock = 1'b0;
    logic [7:0]  shadow [0:MEM_SIZE-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected byte/error whenever the DUT presents one.
    always @(negedge clock) begin
        wr_t e;
        int  ec;
        if (!reset) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_data);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_data", {56'd0, mem_data}, {56'd0, e.data});
                    chk("wr_last", {63'd0, ins_done}, {63'd0, e.last});
                end
                if (mem_addr < MEM_SIZE) shadow[mem_addr[6:0]] = mem_data;
            end else if (ins_done) begin
                checks++; errors++;
                $display("FAIL stray_ins_done: ins_done=1 with mem_we=0, expected 0");
            end
            if (err) begin
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: err_code %0d, no error expected", err_code);
                end else begin
                    ec = eq.pop_front();
                    chk("err_code", {62'd0, err_code}, 64'(ec));
                end
            end
        end
    end

    // Reference model: length table and byte list straight from the ISA layout.
    task automatic model(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                         input logic [3:0] b, input logic [63:0] c, output int len, output bit ok);
        logic [7:0] bytes[$];
        case (ic)
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h3, 4'h4, 4'h5:       len = 10;
            4'h7, 4'h8:             len = 9;
            default:                len = 0;
        endcase
        ok = 1'b0;
        if (len == 0) eq.push_back(1);
        else if ({1'b0, m_pc} + 65'(len) > 65'(MEM_SIZE)) eq.push_back(2);
        else begin
            ok = 1'b1;
            bytes.push_back({ic, f});
            if (len == 2 || len == 10) bytes.push_back({a, b});
            if (len >= 9) for (int k = 0; k < 8; k++) bytes.push_back(8'((c >> (8 * k)) & 64'hFF));
            for (int k = 0; k < len; k++) wq.push_back('{m_pc + 64'(k), bytes[k], (k == len - 1)});
            m_pc = m_pc + 64'(len);
`ifdef INS_HALT_LOCK_EN
            if (ic == 4'h0) m_lock = 1'b1;
`endif
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: in_ready=0 after 40 cycles, expected 1");
        end
    endtask

    task automatic load(input logic [63:0] a);
        addr_load = 1'b1;
        addr_val  = a;
        @(posedge clock); #1;
        addr_load = 1'b0;
        m_pc   = a;
        m_lock = 1'b0;
        @(negedge clock);
        chk("pc_load", pc, m_pc);
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] c, input bit wait_done);
        int len;
        bit ok;
        wait_ready();
        icode = ic; ifun = f; rA = a; rB = b; valC = c;
        in_valid = 1'b1;
        model(ic, f, a, b, c, len, ok);
        @(posedge clock); #1;
        in_valid = 1'b0;
        if (wait_done) begin
            repeat (ok ? len + 1 : 2) @(negedge clock);
            chk("pc_after", pc, m_pc);
        end
    endtask

    initial begin : main
        logic [7:0] exp_irm [0:9];
        int n;
        exp_irm = '{8'h30, 8'hF2, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < MEM_SIZE; i++) shadow[i] = 8'hEE;

        repeat (3) @(negedge clock);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_flags", {60'd0, ins_done, err, err_code}, 64'd0);
        reset = 1'b0;
        #1 chk("rst_ready", {63'd0, in_ready}, 64'd1);

        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h64, 1'b1);
        for (int i = 0; i < 10; i++) chk("irmovq_bytes", {56'd0, shadow[i]}, {56'd0, exp_irm[i]});
        chk("pc_irmovq", pc, 64'd10);
        send(4'h8, 4'h0, 4'hF, 4'hF, 64'h40, 1'b1);
        chk("call_b0", {56'd0, shadow[10]}, 64'h80);
        chk("call_b1", {56'd0, shadow[11]}, 64'h40);
        chk("pc_call", pc, 64'd19);
        send(4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 1'b1);
        chk("opq_bytes", {48'd0, shadow[19], shadow[20]}, 64'h6134);
        chk("pc_opq", pc, 64'd21);

        send(4'hC, 4'h0, 4'h1, 4'h2, 64'h5, 1'b1);
        chk("bad_code", {62'd0, err_code}, 64'd1);
        chk("pc_bad", pc, 64'd21);
        load(64'd120);
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h64, 1'b1);
        chk("ovf_code", {62'd0, err_code}, 64'd2);
        chk("pc_ovf", pc, 64'd120);

        load(64'd127);
        send(4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 1'b1);
        chk("halt_byte", {56'd0, shadow[127]}, 64'h00);
        chk("pc_halt", pc, 64'd128);
`ifdef INS_HALT_LOCK_EN
        chk("halt_lock_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) @(negedge clock);
        chk("halt_lock_hold", {63'd0, in_ready}, 64'd0);
        load(64'd0);
        chk("lock_cleared", {63'd0, in_ready}, 64'd1);
`else
        chk("halt_ready", {63'd0, in_ready}, 64'd1);
        load(64'd0);
`endif

        // Abort an rmmovq while byte 4 is on the bus.
        load(64'd30);
        send(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 1'b0);
        n = 0;
        while (!(mem_we && mem_addr == 64'd33) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("abort_reached_b3", {63'd0, (mem_we && mem_addr == 64'd33)}, 64'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("abort_mem_we", {63'd0, mem_we}, 64'd0);
        chk("abort_pc", pc, 64'd0);
        wq.delete();
        m_pc = '0;
        m_lock = 1'b0;
        @(posedge clock); #2;
        reset = 1'b0;
        #1 chk("abort_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_b3_kept", {56'd0, shadow[33]}, 64'h77);
        @(negedge clock);

        // addr_load wins over in_valid.
        addr_load = 1'b1; addr_val = 64'd50;
        icode = 4'h3; ifun = 4'h0; rA = 4'hF; rB = 4'h2; valC = 64'h9;
        in_valid = 1'b1;
        #1 chk("load_prio_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clock); #1;
        addr_load = 1'b0; in_valid = 1'b0;
        m_pc = 64'd50;
        repeat (3) @(negedge clock);
        chk("load_prio_pc", pc, 64'd50);

        for (int i = 0; i < 80; i++) begin
            if ((i % 6) == 0 || m_lock) load(64'($urandom_range(0, MEM_SIZE - 1)));
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), {$urandom(), $urandom()}, 1'b1);
        end

        repeat (3) @(negedge clock);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("eq_drained", 64'(eq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
